// File: rtl/register_file_sb.sv
// ---------------------------------------------------------------------------
// register_file_sb
//
// Parametrised register file with a write-in-flight scoreboard. Decode reads
// operands and reserves a destination. Writeback writes the data, which also
// releases the reservation. The top register (index 2**SEL_WIDTH-1) is the
// program counter and supports load and increment.
//
// Optional feature macro: ZERO_REG_EN
//   defined   -> register 0 is hardwired to zero. It can never be busy,
//                writes to it are dropped, and reserving it always succeeds.
//   undefined -> register 0 is an ordinary register.
//
// Ports
//   clk      in   clock; all state changes on the rising edge
//   rst_n    in   asynchronous active-low reset
//   wr_en    in   write strobe; also releases busy[wr_sel]
//   wr_sel   in   write register index
//   wr_data  in   write data
//   rd_sel   in   packed read indices; port i = [i*SEL_WIDTH +: SEL_WIDTH]
//   rd_data  out  packed read data (combinational, with write-through bypass)
//   rd_busy  out  per-port: selected register has a pending write
//   rsv_en   in   reserve request for rsv_sel
//   rsv_sel  in   register to reserve
//   rsv_ok   out  reservation accepted this cycle
//   pc_ld    in   load PC from pc_in
//   pc_in    in   PC load value
//   pc_inc   in   increment PC by one (wraps)
//   pc_out   out  registered PC value (no bypass)
// ---------------------------------------------------------------------------
module register_file_sb #(
    parameter int BIT_WIDTH = 32,
    parameter int SEL_WIDTH = 5,
    parameter int NUM_RD    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [SEL_WIDTH-1:0]          wr_sel,
    input  logic [BIT_WIDTH-1:0]          wr_data,
    input  logic [NUM_RD*SEL_WIDTH-1:0]   rd_sel,
    output logic [NUM_RD*BIT_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]             rd_busy,
    input  logic                          rsv_en,
    input  logic [SEL_WIDTH-1:0]          rsv_sel,
    output logic                          rsv_ok,
    input  logic                          pc_ld,
    input  logic [BIT_WIDTH-1:0]          pc_in,
    input  logic                          pc_inc,
    output logic [BIT_WIDTH-1:0]          pc_out
);

    localparam int                 DEPTH  = 2 ** SEL_WIDTH;
    localparam int                 PC_IDX = DEPTH - 1;
    localparam logic [SEL_WIDTH-1:0] PC_SEL = SEL_WIDTH'(PC_IDX);

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [BIT_WIDTH-1:0] regs_q [DEPTH];
    logic [BIT_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_d;

    logic wr_pc;
    logic wr_allowed;
    logic rsv_wr_hit;
    logic rsv_is_zero;

    assign wr_pc       = wr_en && (wr_sel == PC_SEL);
    assign wr_allowed  = wr_en && !(ZERO_REG && (wr_sel == '0));
    assign rsv_wr_hit  = wr_en && (wr_sel == rsv_sel);
    assign rsv_is_zero = ZERO_REG && (rsv_sel == '0);

    // A register being written this cycle is released on the same edge, so a
    // reservation against it can be granted immediately.
    assign rsv_ok = rsv_en && (!busy_q[rsv_sel] || rsv_wr_hit || rsv_is_zero);

    // Next-state. Ordering implements the priorities: the PC load/increment is
    // overridden by an explicit write to the PC index, and a same-cycle
    // reserve overrides the release from a write so the register stays busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;

        if (!wr_pc) begin
            if (pc_ld) begin
                regs_d[PC_IDX] = pc_in;
            end else if (pc_inc) begin
                regs_d[PC_IDX] = regs_q[PC_IDX] + BIT_WIDTH'(1);
            end
        end

        if (wr_allowed) begin
            regs_d[wr_sel] = wr_data;
            busy_d[wr_sel] = 1'b0;
        end

        if (rsv_ok && !rsv_is_zero) begin
            busy_d[rsv_sel] = 1'b1;
        end
    end

    genvar gi;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[gi] <= '0;
                    busy_q[gi] <= 1'b0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                    busy_q[gi] <= busy_d[gi];
                end
            end
        end
    endgenerate

    // Combinational read ports with write-through bypass. A same-cycle write
    // to the selected register both forwards its data and masks busy, since
    // that write is the release.
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [SEL_WIDTH-1:0] sel;
            logic                 hit;
            logic                 is_zero;

            assign sel     = rd_sel[gi*SEL_WIDTH +: SEL_WIDTH];
            assign hit     = wr_en && (wr_sel == sel);
            assign is_zero = ZERO_REG && (sel == '0);

            assign rd_data[gi*BIT_WIDTH +: BIT_WIDTH] =
                is_zero ? '0 : (hit ? wr_data : regs_q[sel]);
            assign rd_busy[gi] = !is_zero && busy_q[sel] && !hit;
        end
    endgenerate

    assign pc_out = regs_q[PC_IDX];

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

    localparam int BW  = 32;
    localparam int SW  = 5;
    localparam int NRD = 2;
    localparam int DEP = 2 ** SW;

`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [SW-1:0]     wr_sel;
    logic [BW-1:0]     wr_data;
    logic [NRD*SW-1:0] rd_sel;
    logic [NRD*BW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              rsv_en;
    logic [SW-1:0]     rsv_sel;
    logic              rsv_ok;
    logic              pc_ld;
    logic [BW-1:0]     pc_in;
    logic              pc_inc;
    logic [BW-1:0]     pc_out;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: architectural register contents and pending flags.
    logic [BW-1:0] m_regs [DEP];
    bit            m_busy [DEP];

    register_file_sb #(.BIT_WIDTH(BW), .SEL_WIDTH(SW), .NUM_RD(NRD)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_sel(rd_sel), .rd_data(rd_data), .rd_busy(rd_busy),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsv_ok(rsv_ok),
        .pc_ld(pc_ld), .pc_in(pc_in), .pc_inc(pc_inc), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] exp_rd(input logic [SW-1:0] s);
        if (ZR && s == 0) return '0;
        if (wr_en && wr_sel == s) return wr_data;
        return m_regs[s];
    endfunction

    function automatic logic exp_busy(input logic [SW-1:0] s);
        if (ZR && s == 0) return 1'b0;
        return m_busy[s] && !(wr_en && wr_sel == s);
    endfunction

    function automatic logic exp_rsv_ok();
        if (!rsv_en) return 1'b0;
        if (ZR && rsv_sel == 0) return 1'b1;
        return !m_busy[rsv_sel] || (wr_en && wr_sel == rsv_sel);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Advance one clock: apply the architectural update rules to the model
    // from the inputs currently driven, then let the DUT take the edge.
    task automatic tick();
        bit            grant;
        logic [BW-1:0] pc_next;
        grant   = exp_rsv_ok();
        pc_next = m_regs[DEP-1];
        if (pc_ld)       pc_next = pc_in;
        else if (pc_inc) pc_next = m_regs[DEP-1] + 1;
        m_regs[DEP-1] = pc_next;
        if (wr_en && !(ZR && wr_sel == 0)) begin
            m_regs[wr_sel] = wr_data;
            m_busy[wr_sel] = 1'b0;
        end
        if (grant && !(ZR && rsv_sel == 0)) m_busy[rsv_sel] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_sel = '0; wr_data = '0; rd_sel = '0;
        rsv_en = 0; rsv_sel = '0; pc_ld = 0; pc_in = '0; pc_inc = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        model_reset();
        rd_sel = {5'd31, 5'd5};
        #1;
        vectors++;
        if (rd_data !== '0) begin
            miscompares++;
            $display("FAIL reset_rd_data got=%h want=0", rd_data);
        end
        vectors++;
        if (pc_out !== '0 || rd_busy !== '0) begin
            miscompares++;
            $display("FAIL reset_pc_busy got pc=%h busy=%b want 0/0", pc_out, rd_busy);
        end
        rst_n = 1'b1;
        #1;
        wr_en = 1; wr_sel = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 0;
        #1;
        vectors++;
        if (rd_data[BW-1:0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL reset_readback got=%h want=deadbeef", rd_data[BW-1:0]);
        end
        $display("reset: r5 readback %h", rd_data[BW-1:0]);
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_sel = 5'd7; wr_data = 32'h1234; rd_sel = {5'd7, 5'd7};
        #1;
        vectors++;
        if (rd_data !== {32'h1234, 32'h1234}) begin
            miscompares++;
            $display("FAIL bypass_same_cycle got=%h want=00001234_00001234", rd_data);
        end
        tick();
        wr_en = 0; wr_data = 32'hFFFF_0000;
        #1;
        vectors++;
        if (rd_data !== {32'h1234, 32'h1234}) begin
            miscompares++;
            $display("FAIL bypass_stored got=%h want=00001234_00001234", rd_data);
        end
        $display("bypass: r7 = %h", rd_data[BW-1:0]);
    endtask

    task automatic test_scoreboard();
        rsv_en = 1; rsv_sel = 5'd3; rd_sel = {5'd3, 5'd3};
        #1;
        vectors++;
        if (rsv_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_first_rsv got=%b want=1", rsv_ok);
        end
        tick();
        vectors++;
        if (rd_busy !== 2'b11 || rsv_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_busy got busy=%b ok=%b want 11/0", rd_busy, rsv_ok);
        end
        tick();
        rsv_en = 0;
        wr_en = 1; wr_sel = 5'd3; wr_data = 32'h55;
        #1;
        vectors++;
        if (rd_busy !== 2'b00 || rd_data[BW-1:0] !== 32'h55) begin
            miscompares++;
            $display("FAIL sb_release got busy=%b data=%h want 00/55", rd_busy, rd_data[BW-1:0]);
        end
        tick();
        wr_en = 0;
        #1;
        vectors++;
        if (rd_busy !== 2'b00 || rd_data[BW-1:0] !== 32'h55) begin
            miscompares++;
            $display("FAIL sb_after got busy=%b data=%h want 00/55", rd_busy, rd_data[BW-1:0]);
        end
        $display("scoreboard: r3 busy=%b data=%h", rd_busy, rd_data[BW-1:0]);
    endtask

    task automatic test_rsv_write();
        rsv_en = 1; rsv_sel = 5'd9; rd_sel = {5'd9, 5'd9};
        tick();
        wr_en = 1; wr_sel = 5'd9; wr_data = 32'hA5A5A5A5;
        #1;
        vectors++;
        if (rsv_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL rsvwr_ok got=%b want=1", rsv_ok);
        end
        tick();
        wr_en = 0; rsv_en = 0;
        #1;
        vectors++;
        if (rd_data[BW-1:0] !== 32'hA5A5A5A5 || rd_busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rsvwr_after got data=%h busy=%b want a5a5a5a5/1", rd_data[BW-1:0], rd_busy[0]);
        end
        // Release r9 so later tests start from a clean scoreboard entry.
        wr_en = 1; wr_sel = 5'd9; wr_data = 32'hA5A5A5A5;
        tick();
        wr_en = 0;
        $display("rsv+write: r9 = %h", rd_data[BW-1:0]);
    endtask

    task automatic test_pc();
        pc_ld = 1; pc_in = 32'hFFFFFFFF;
        tick();
        pc_ld = 0;
        vectors++;
        if (pc_out !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL pc_load got=%h want=ffffffff", pc_out);
        end
        pc_inc = 1;
        tick();
        pc_inc = 0;
        vectors++;
        if (pc_out !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_wrap got=%h want=0", pc_out);
        end
        pc_ld = 1; pc_inc = 1; pc_in = 32'h100;
        tick();
        pc_inc = 0;
        vectors++;
        if (pc_out !== 32'h100) begin
            miscompares++;
            $display("FAIL pc_ld_over_inc got=%h want=100", pc_out);
        end
        pc_in = 32'h80; wr_en = 1; wr_sel = 5'd31; wr_data = 32'h40;
        rd_sel = {5'd31, 5'd31};
        #1;
        vectors++;
        if (pc_out !== 32'h100 || rd_data[BW-1:0] !== 32'h40) begin
            miscompares++;
            $display("FAIL pc_no_bypass got pc=%h rd=%h want 100/40", pc_out, rd_data[BW-1:0]);
        end
        tick();
        pc_ld = 0; wr_en = 0;
        vectors++;
        if (pc_out !== 32'h40) begin
            miscompares++;
            $display("FAIL pc_wr_priority got=%h want=40", pc_out);
        end
        $display("pc: final %h", pc_out);
    endtask

    task automatic test_zero_reg();
        logic [BW-1:0] want;
        want = ZR ? 32'h0 : 32'hFF;
        wr_en = 1; wr_sel = 5'd0; wr_data = 32'hFF; rd_sel = {5'd0, 5'd0};
        #1;
        vectors++;
        if (rd_data[BW-1:0] !== want) begin
            miscompares++;
            $display("FAIL r0_bypass got=%h want=%h", rd_data[BW-1:0], want);
        end
        tick();
        wr_en = 0;
        rsv_en = 1; rsv_sel = 5'd0;
        #1;
        vectors++;
        if (rsv_ok !== 1'b1 || rd_data[BW-1:0] !== want) begin
            miscompares++;
            $display("FAIL r0_rsv got ok=%b data=%h want 1/%h", rsv_ok, rd_data[BW-1:0], want);
        end
        tick();
        rsv_en = 0;
        vectors++;
        if (rd_busy[0] !== !ZR) begin
            miscompares++;
            $display("FAIL r0_busy got=%b want=%b", rd_busy[0], !ZR);
        end
        // Clear any busy left on r0 in the ordinary-register build.
        wr_en = 1; wr_sel = 5'd0; wr_data = 32'h0;
        tick();
        wr_en = 0;
        $display("zero_reg: r0 busy=%b", rd_busy[0]);
    endtask

    task automatic test_random();
        logic [SW-1:0] s;
        for (int n = 0; n < 400; n++) begin
            // Narrow index range so collisions between ports are frequent.
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_sel  = ($urandom_range(0, 5) == 0) ? 5'd31 : SW'($urandom_range(0, 6));
            wr_data = $urandom;
            rsv_en  = ($urandom_range(0, 1) == 0);
            rsv_sel = ($urandom_range(0, 5) == 0) ? 5'd31 : SW'($urandom_range(0, 6));
            for (int p = 0; p < NRD; p++)
                rd_sel[p*SW +: SW] = ($urandom_range(0, 5) == 0) ? 5'd31 : SW'($urandom_range(0, 6));
            pc_ld   = ($urandom_range(0, 4) == 0);
            pc_in   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            pc_inc  = ($urandom_range(0, 2) == 0);
            #1;
            for (int p = 0; p < NRD; p++) begin
                s = rd_sel[p*SW +: SW];
                vectors++;
                if (rd_data[p*BW +: BW] !== exp_rd(s) || rd_busy[p] !== exp_busy(s)) begin
                    miscompares++;
                    $display("FAIL rand_rd n=%0d p=%0d sel=%0d got=%h/%b want=%h/%b",
                             n, p, s, rd_data[p*BW +: BW], rd_busy[p], exp_rd(s), exp_busy(s));
                end
            end
            vectors++;
            if (rsv_ok !== exp_rsv_ok() || pc_out !== m_regs[DEP-1]) begin
                miscompares++;
                $display("FAIL rand_ctl n=%0d got ok=%b pc=%h want ok=%b pc=%h",
                         n, rsv_ok, pc_out, exp_rsv_ok(), m_regs[DEP-1]);
            end
            tick();
        end
        idle_inputs();
        $display("random: 400 cycles done");
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        rst_n = 1'b1;
        test_reset();
        test_bypass();
        test_scoreboard();
        test_rsv_write();
        test_pc();
        test_zero_reg();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
